// File: rtl/vga_timing_generator.sv
// Free-running 640x480@60 VGA raster counter: sync, blanking and clamped pixel coordinates.
// Define VGA_TIMING_REGISTERED_OUT_EN to register all six outputs (one extra cycle of latency).
module vga_timing_generator #(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK_PORCH  = 33
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       screenEnd,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic [9:0] x,
    output logic [8:0] y
);

    localparam int H_TOTAL    = WIDTH + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL    = HEIGHT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int H_SYNC_BEG = WIDTH + H_FRONT_PORCH;
    localparam int H_SYNC_END = WIDTH + H_FRONT_PORCH + H_SYNC - 1;
    localparam int V_SYNC_BEG = HEIGHT + V_FRONT_PORCH;
    localparam int V_SYNC_END = HEIGHT + V_FRONT_PORCH + V_SYNC - 1;

    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        h_count_d = h_count_q + 10'd1;
        v_count_d = v_count_q;
        if (h_count_q == 10'(H_TOTAL - 1)) begin
            h_count_d = '0;
            if (v_count_q == 10'(V_TOTAL - 1)) begin
                v_count_d = '0;
            end else begin
                v_count_d = v_count_q + 10'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            h_count_q <= '0;
            v_count_q <= '0;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
        end
    end

    logic       active_c;
    logic       hsync_c;
    logic       vsync_c;
    logic       screen_end_c;
    logic [9:0] x_c;
    logic [8:0] y_c;

    always_comb begin
        active_c     = (h_count_q < 10'(WIDTH)) && (v_count_q < 10'(HEIGHT));
        hsync_c      = !((h_count_q >= 10'(H_SYNC_BEG)) && (h_count_q <= 10'(H_SYNC_END)));
        vsync_c      = !((v_count_q >= 10'(V_SYNC_BEG)) && (v_count_q <= 10'(V_SYNC_END)));
        screen_end_c = (h_count_q == 10'(WIDTH)) && (v_count_q == 10'(HEIGHT));
        // Clamp during blanking so x + WIDTH*y never leaves image RAM.
        x_c          = (h_count_q < 10'(WIDTH))  ? h_count_q      : 10'(WIDTH - 1);
        y_c          = (v_count_q < 10'(HEIGHT)) ? v_count_q[8:0] : 9'(HEIGHT - 1);
    end

`ifdef VGA_TIMING_REGISTERED_OUT_EN
    logic       active_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       screen_end_q;
    logic [9:0] x_q;
    logic [8:0] y_q;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            active_q     <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            screen_end_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            active_q     <= active_c;
            hsync_q      <= hsync_c;
            vsync_q      <= vsync_c;
            screen_end_q <= screen_end_c;
            x_q          <= x_c;
            y_q          <= y_c;
        end
    end

    assign active    = active_q;
    assign hSync     = hsync_q;
    assign vSync     = vsync_q;
    assign screenEnd = screen_end_q;
    assign x         = x_q;
    assign y         = y_q;
`else
    assign active    = active_c;
    assign hSync     = hsync_c;
    assign vSync     = vsync_c;
    assign screenEnd = screen_end_c;
    assign x         = x_c;
    assign y         = y_c;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a full-size instance plus a shrunken-timing instance for whole-frame checks.
// Expected outputs come from the raster position computed as (edges since reset) modulo line/frame length.
module tb_vga_timing_generator;

`ifdef VGA_TIMING_REGISTERED_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    // Shrunken timing: 16-clock lines, 12-line frames, 192-clock frames.
    localparam int SW = 8, SHFP = 2, SHS = 3, SHBP = 3;
    localparam int SH = 6, SVFP = 2, SVS = 2, SVBP = 2;
    localparam int S_FRAME = (SW + SHFP + SHS + SHBP) * (SH + SVFP + SVS + SVBP);

    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       se;
        logic [9:0] x;
        logic [8:0] y;
    } vga_out_t;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       f_se, f_active, f_hsync, f_vsync;
    logic [9:0] f_x;
    logic [8:0] f_y;
    logic       s_se, s_active, s_hsync, s_vsync;
    logic [9:0] s_x;
    logic [8:0] s_y;
    vga_out_t   got_f, got_s, exp_f, exp_s;

    int      checks = 0;
    int      errors = 0;
    longint  t = 0;

    always #5 clk25 = ~clk25;

    vga_timing_generator dut_full (
        .clk25(clk25), .reset(rst_n), .screenEnd(f_se), .active(f_active),
        .hSync(f_hsync), .vSync(f_vsync), .x(f_x), .y(f_y)
    );

    vga_timing_generator #(
        .WIDTH(SW), .HEIGHT(SH), .H_FRONT_PORCH(SHFP), .H_SYNC(SHS), .H_BACK_PORCH(SHBP),
        .V_FRONT_PORCH(SVFP), .V_SYNC(SVS), .V_BACK_PORCH(SVBP)
    ) dut_small (
        .clk25(clk25), .reset(rst_n), .screenEnd(s_se), .active(s_active),
        .hSync(s_hsync), .vSync(s_vsync), .x(s_x), .y(s_y)
    );

    assign got_f = {f_active, f_hsync, f_vsync, f_se, f_x, f_y};
    assign got_s = {s_active, s_hsync, s_vsync, s_se, s_x, s_y};

    // Expected outputs after tc rising edges since reset release.
    function automatic vga_out_t model(input int w, hfp, hs, hbp, hh, vfp, vs, vbp, input longint tc);
        vga_out_t o;
        longint   tt, h, v, htot, vtot;
        htot = w + hfp + hs + hbp;
        vtot = hh + vfp + vs + vbp;
        if (LAT == 1 && tc == 0) begin
            o = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, se: 1'b0, x: 10'd0, y: 9'd0};
            return o;
        end
        tt       = tc - LAT;
        h        = tt % htot;
        v        = (tt / htot) % vtot;
        o.active = (h < w) && (v < hh);
        o.hsync  = !(h >= w + hfp && h < w + hfp + hs);
        o.vsync  = !(v >= hh + vfp && v < hh + vfp + vs);
        o.se     = (h == w) && (v == hh);
        o.x      = 10'((h < w) ? h : w - 1);
        o.y      = 9'((v < hh) ? v : hh - 1);
        return o;
    endfunction

    function automatic vga_out_t model_full(input longint tc);
        return model(640, 16, 96, 48, 480, 10, 2, 33, tc);
    endfunction

    function automatic vga_out_t model_small(input longint tc);
        return model(SW, SHFP, SHS, SHBP, SH, SVFP, SVS, SVBP, tc);
    endfunction

    // Advance one edge and settle to a sampling point 1 ns after it.
    task automatic tick();
        @(posedge clk25);
        if (rst_n) t++;
        #1;
        exp_f = model_full(t);
        exp_s = model_small(t);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        t     = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL reset_full cyc=%0d got=%h exp=%h", i, got_f, exp_f);
            end
            checks++;
            if (f_x !== 10'd0 || f_y !== 9'd0 || f_hsync !== 1'b1 || f_vsync !== 1'b1 ||
                f_se !== 1'b0 || f_active !== (LAT == 0)) begin
                errors++;
                $display("FAIL reset_values got=%h", got_f);
            end
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, got_s, exp_s);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (f_x !== 10'(3 - LAT)) begin
            errors++;
            $display("FAIL x_after_3 got=%0d exp=%0d", f_x, 3 - LAT);
        end
    endtask

    // Small instance across several frames: every cycle against the model, pulse spacing measured directly.
    task automatic test_frame();
        longint last  = -1;
        int     count = 0;
        while (t < 4 * S_FRAME + 20) begin
            tick();
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL frame_small t=%0d got=%h exp=%h", t, got_s, exp_s);
            end
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL frame_full t=%0d got=%h exp=%h", t, got_f, exp_f);
            end
            if (s_se === 1'b1) begin
                count++;
                checks++;
                if (last < 0 ? (t != (SW + 16 * SH + LAT)) : (t - last != S_FRAME)) begin
                    errors++;
                    $display("FAIL screen_end_spacing t=%0d last=%0d", t, last);
                end
                last = t;
            end
        end
        checks++;
        if (count != 4) begin
            errors++;
            $display("FAIL screen_end_count got=%0d exp=4", count);
        end
    endtask

    // Full instance through the second line, with spot checks at the line landmarks.
    task automatic test_line();
        while (t < 1700) begin
            tick();
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL line_full t=%0d got=%h exp=%h", t, got_f, exp_f);
            end
            if (t == 800 + LAT) begin
                checks++;
                if (f_x !== 10'd0 || f_y !== 9'd1 || f_active !== 1'b1) begin
                    errors++;
                    $display("FAIL line_wrap x=%0d y=%0d active=%b", f_x, f_y, f_active);
                end
            end
            if (t == 1440 + LAT) begin
                checks++;
                if (f_active !== 1'b0 || f_x !== 10'd639) begin
                    errors++;
                    $display("FAIL hblank_start active=%b x=%0d", f_active, f_x);
                end
            end
            if (t == 1456 + LAT || t == 1552 + LAT) begin
                checks++;
                if (f_hsync !== (t == 1552 + LAT)) begin
                    errors++;
                    $display("FAIL hsync_edge t=%0d got=%b", t, f_hsync);
                end
            end
        end
    endtask

    // Asynchronous reset between edges, at a random sub-cycle offset, after a random run.
    task automatic test_async_reset(input int run);
        for (int i = 0; i < run; i++) begin
            tick();
            checks++;
            if (got_f !== exp_f || got_s !== exp_s) begin
                errors++;
                $display("FAIL run t=%0d full=%h/%h small=%h/%h", t, got_f, exp_f, got_s, exp_s);
            end
        end
        #($urandom_range(1, 7));
        rst_n = 1'b0;
        t     = 0;
        #1;
        checks++;
        if (got_f !== model_full(0) || got_s !== model_small(0)) begin
            errors++;
            $display("FAIL async_reset full=%h small=%h", got_f, got_s);
        end
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (got_f !== exp_f || got_s !== exp_s) begin
                errors++;
                $display("FAIL restart t=%0d full=%h/%h small=%h/%h", t, got_f, exp_f, got_s, exp_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_line();
        test_async_reset(1100 - int'(t) + 1700 - 1700);
        for (int k = 0; k < 6; k++) test_async_reset(int'($urandom_range(50, 900)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Free-running raster counter that produces VGA sync, blanking and pixel-coordinate signals for a 640x480 display at 60 Hz, driven by a 25 MHz pixel clock. It sits between the clock divider and the pixel pipeline in `VGAController`. It supplies `x`/`y` for image-RAM addressing and sprite hit tests, `active` for output blanking, and a one-cycle `screenEnd` pulse that gates once-per-frame game-state updates.

## Interface
Parameters:
- `WIDTH`, 640, visible pixels per line
- `HEIGHT`, 480, visible lines per frame
- `H_FRONT_PORCH`, 16, pixel clocks after visible region before hSync
- `H_SYNC`, 96, hSync pulse width in pixel clocks
- `H_BACK_PORCH`, 48, pixel clocks after hSync
- `V_FRONT_PORCH`, 10, lines after visible region before vSync
- `V_SYNC`, 2, vSync pulse width in lines
- `V_BACK_PORCH`, 33, lines after vSync

Ports:
- `clk25` in 1: pixel clock. One clock, rising edge only.
- `reset` in 1: asynchronous, active-low reset.
- `screenEnd` out 1: one-cycle pulse, once per frame.
- `active` out 1: high while the current pixel is visible.
- `hSync` out 1: horizontal sync, active low.
- `vSync` out 1: vertical sync, active low.
- `x` out 10: pixel column from the left.
- `y` out 9: pixel row from the top.

## Operation
- Internal counters: `hCount` and `vCount`, both 10 bits.
  - H_TOTAL = sum of the H parameters = 800. V_TOTAL = sum of the V parameters = 525.
- Each `clk25` edge, `hCount` increments.
  - At H_TOTAL-1 it wraps to 0 and `vCount` increments.
  - `vCount` wraps from V_TOTAL-1 to 0 on that same edge.
- `active` = (`hCount` < WIDTH) && (`vCount` < HEIGHT).
- `hSync` = 0 iff `hCount` is in [WIDTH+H_FRONT_PORCH, WIDTH+H_FRONT_PORCH+H_SYNC-1], i.e. [656,751].
- `vSync` = 0 iff `vCount` is in [HEIGHT+V_FRONT_PORCH, HEIGHT+V_FRONT_PORCH+V_SYNC-1], i.e. [490,491]. vSync spans whole lines.
- `screenEnd` = 1 iff `hCount`==WIDTH && `vCount`==HEIGHT. This is the first blanking pixel after the last visible pixel of the frame.
- `x` = `hCount` when `hCount` < WIDTH, otherwise WIDTH-1 (clamped).
- `y` = `vCount[8:0]` when `vCount` < HEIGHT, otherwise HEIGHT-1 (clamped). Clamping keeps `x + 640*y` inside image RAM during blanking.
- No other state; the counters never stall.

## Timing
- Base build: all outputs are combinational decodes of the counters, so there is zero latency from the counter state.
- While `reset`=0, both counters are 0 regardless of clock. Resulting output values:
  - `x`=0, `y`=0
  - `active`=1
  - `hSync`=1, `vSync`=1
  - `screenEnd`=0
- On release, the first rising edge moves `hCount` to 1.
- Reset asserted mid-frame clears the counters immediately (asynchronous); the next frame starts at (0,0).
- Line period is 800 cycles. Frame period is 420000 cycles. `screenEnd` is high for exactly one cycle per frame.
- Line wrap: the edge after (`hCount`=799, `vCount`=n) gives (0, n+1). The edge after (799, 524) gives (0, 0).

## Configuration
- `VGA_TIMING_REGISTERED_OUT_EN`
- Defined:
  - All six outputs are registered, adding exactly one `clk25` cycle of latency relative to the base decode.
  - Their relative alignment is unchanged.
  - Output register reset values: `hSync`=1, `vSync`=1, `active`=0, `screenEnd`=0, `x`=0, `y`=0.
- Undefined: combinational outputs as described above.

## Test plan
- Hold `reset`=0 for 5 cycles, then release → during reset `x`=0, `y`=0, `active`=1, `hSync`=`vSync`=1, `screenEnd`=0; after 3 edges `x`=3.
- Count from reset release → `active` falls at cycle 640, with `x` held at 639 from then on. `hSync` falls at cycle 656 and rises at 752. At cycle 800, `x`=0, `y`=1, `active`=1.
- Run a full frame → `screenEnd` high only at cycle 384640 (h=640, v=480). The next pulse comes exactly 420000 cycles later.
- Run a full frame → `vSync` low from cycle 392000 through 393599 (lines 490-491, 1600 cycles). `y` stays 479 throughout vertical blanking. The counters return to (0,0) at cycle 420000.
- Assert `reset` at (h=300, v=200) with no clock edge → outputs return to their reset values immediately. After release, the sequence restarts from (0,0).
- With `VGA_TIMING_REGISTERED_OUT_EN` defined, repeat the first three scenarios → every transition occurs exactly one cycle later, and `active`=0 during reset.
